// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and helpers for the Nios II OCI data-trace capture buffer.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    StCapture,
    StFrozen,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned entry_w(input int unsigned cnt_w, input int unsigned dct_w);
    return cnt_w + dct_w;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module nios2_oci_trace_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 34,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Circular capture buffer for OCI data-trace frames: capture, freeze, then drain over valid/ready.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned DCT_W     = 30,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = 1,
  parameter int unsigned OVF_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dct_valid,
  input  logic [DCT_W-1:0]           dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CNT_W+DCT_W-1:0]     rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic                       frozen,
  output logic                       drain_done
);

  localparam int unsigned EntryW = entry_w(CNT_W, DCT_W);
  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);

  state_e              state_q, state_d;
  logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]   level_q, level_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic                rd_valid_q, rd_valid_d;
  logic                frozen_q, frozen_d;
  logic                done_q, done_d;
  logic                wr_qual, full, pop, we;
  logic [EntryW-1:0]   ram_rdata;

  assign wr_qual = (state_q == StCapture) && dct_valid && (dct_count != '0);
  assign full    = (level_q == LevelFull);
  // rd_valid_q is only ever set in DRAIN, so it gates pops to that state.
  assign pop     = rd_valid_q && rd_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    we       = 1'b0;

    if (wr_qual) begin
      if (!full) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + AddrW'(1);
        level_d  = level_q + LevelW'(1);
      end else begin
        ovf_d = OVF_W'(sat_inc(32'(ovf_q), OVF_W));
        if (WRAP_MODE != 0) begin
          // Overwrite the oldest slot; level stays at DEPTH.
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrW'(1);
          rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
      level_d  = level_q - LevelW'(1);
    end

    unique case (state_q)
      StCapture: begin
        if (test_has_ended) begin
          state_d = StDrain;
        end else if (test_ending) begin
          state_d = StFrozen;
        end
      end
      StFrozen: begin
        if (test_has_ended) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (level_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StCapture;
    endcase

    rd_valid_d = (state_d == StDrain) && (level_d != '0);
    frozen_d   = (state_d != StCapture);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StCapture;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      frozen_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      frozen_q   <= frozen_d;
      done_q     <= done_d;
    end
  end

  nios2_oci_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW),
    .ADDR_W(AddrW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata({dct_count, dct_buffer}),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_valid_q ? ram_rdata : '0;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  assign frozen       = frozen_q;
  assign drain_done   = done_q;

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Scoreboard bench: three buffers (depth 4 wrap, depth 4 drop, default depth 16) share stimulus.
module tb_nios2_oci_trace_capture;

  localparam int unsigned DW = 30;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = CW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, dct_valid, test_ending, test_has_ended, rd_ready;
  logic [DW-1:0] dct_buffer;
  logic [CW-1:0] dct_count;

  logic          rv_w, rv_d, rv_b;
  logic [EW-1:0] rd_w, rd_d, rd_b;
  logic [2:0]    lv_w, lv_d;
  logic [4:0]    lv_b;
  logic [2:0]    ov_w, ov_d;
  logic [15:0]   ov_b;
  logic          fz_w, fz_d, fz_b, dn_w, dn_d, dn_b;

  nios2_oci_trace_capture #(.DCT_W(DW), .CNT_W(CW), .DEPTH(4), .WRAP_MODE(1), .OVF_W(3)) dut_w (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rv_w), .rd_data(rd_w), .level(lv_w),
    .overflow_cnt(ov_w), .frozen(fz_w), .drain_done(dn_w)
  );

  nios2_oci_trace_capture #(.DCT_W(DW), .CNT_W(CW), .DEPTH(4), .WRAP_MODE(0), .OVF_W(3)) dut_d (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rv_d), .rd_data(rd_d), .level(lv_d),
    .overflow_cnt(ov_d), .frozen(fz_d), .drain_done(dn_d)
  );

  nios2_oci_trace_capture dut_b (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rv_b), .rd_data(rd_b), .level(lv_b),
    .overflow_cnt(ov_b), .frozen(fz_b), .drain_done(dn_b)
  );

  // Reference model: each queue is the exact readout order expected from its buffer.
  logic [EW-1:0] q_w[$], q_d[$], q_b[$];
  int ovf_m[3];
  int mode;  // 0 capture, 1 frozen, 2 drain, 3 done
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_frame(input logic [EW-1:0] e);
    if (q_w.size() == 4) begin
      void'(q_w.pop_front());
      ovf_m[0]++;
    end
    q_w.push_back(e);
    if (q_d.size() == 4) ovf_m[1]++;
    else q_d.push_back(e);
    if (q_b.size() == 16) begin
      void'(q_b.pop_front());
      ovf_m[2]++;
    end
    q_b.push_back(e);
  endtask

  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic te, input logic th, input logic rr);
    @(posedge clk);
    #1;
    dct_valid = v; dct_count = c; dct_buffer = d;
    test_ending = te; test_has_ended = th; rd_ready = rr;
    if (mode == 0 && v && c != 0) model_frame({c, d});
    if (mode == 0) begin
      if (th) mode = 2;
      else if (te) mode = 1;
    end else if (mode == 1 && th) begin
      mode = 2;
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    q_w.delete(); q_d.delete(); q_b.delete();
    ovf_m = '{0, 0, 0};
    mode = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_st(input string tag);
    idle();
    @(negedge clk);
    check({tag, ".level_w"}, 64'(lv_w), 64'(q_w.size()));
    check({tag, ".level_d"}, 64'(lv_d), 64'(q_d.size()));
    check({tag, ".level_b"}, 64'(lv_b), 64'(q_b.size()));
    check({tag, ".ovf_w"}, 64'(ov_w), 64'(sat(ovf_m[0], 7)));
    check({tag, ".ovf_d"}, 64'(ov_d), 64'(sat(ovf_m[1], 7)));
    check({tag, ".ovf_b"}, 64'(ov_b), 64'(sat(ovf_m[2], 65535)));
    check({tag, ".frozen"}, 64'({fz_w, fz_d, fz_b}), (mode != 0) ? 64'h7 : 64'h0);
    check({tag, ".drain_done"}, 64'({dn_w, dn_d, dn_b}), (mode == 3) ? 64'h7 : 64'h0);
    check({tag, ".rd_valid"}, 64'({rv_w, rv_d, rv_b}), 64'h0);
  endtask

  // Caller has already raised test_has_ended; stall cycles hold rd_ready low first.
  task automatic drain(input int stall, input bit rand_ready);
    int n;
    for (int i = 0; i < stall; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    if (stall > 0) begin
      @(negedge clk);
      check("stall.rd_valid_w", 64'(rv_w), (q_w.size() != 0) ? 64'h1 : 64'h0);
      check("stall.rd_valid_b", 64'(rv_b), (q_b.size() != 0) ? 64'h1 : 64'h0);
      check("stall.level_w", 64'(lv_w), 64'(q_w.size()));
      check("stall.level_b", 64'(lv_b), 64'(q_b.size()));
    end
    n = 0;
    while (!(dn_w && dn_d && dn_b) && n < 200) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      n++;
    end
    check("drain.in_budget", 64'(n < 200), 64'h1);
    check("drain.model_empty", 64'(q_w.size() + q_d.size() + q_b.size()), 64'h0);
    mode = 3;
    check_st("done");
  endtask

  task automatic mon(input int i, input logic v, input logic [EW-1:0] d);
    int sz;
    logic [EW-1:0] e;
    if (v !== 1'b1) return;
    sz = (i == 0) ? q_w.size() : (i == 1) ? q_d.size() : q_b.size();
    if (sz == 0) begin
      check($sformatf("rd_valid_unexpected[%0d]", i), 64'(v), 64'h0);
      return;
    end
    e = (i == 0) ? q_w[0] : (i == 1) ? q_d[0] : q_b[0];
    check($sformatf("rd_data[%0d]", i), 64'(d), 64'(e));
    if (rd_ready === 1'b1) begin
      case (i)
        0:       void'(q_w.pop_front());
        1:       void'(q_d.pop_front());
        default: void'(q_b.pop_front());
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon(0, rv_w, rd_w);
      mon(1, rv_d, rd_d);
      mon(2, rv_b, rd_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    mode = 0;
    ovf_m = '{0, 0, 0};

    // Reset state and basic capture/drain
    do_reset();
    @(negedge clk);
    check("reset.rd_data", 64'({rd_w, rd_b}), 64'h0);
    check_st("reset");
    for (int k = 1; k <= 3; k++) cycle(1'b1, CW'(k), DW'(k), 1'b0, 1'b0, 1'b0);
    check_st("basic");
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    drain(0, 1'b0);

    // Wrap / drop when full
    do_reset();
    for (int k = 1; k <= 6; k++) cycle(1'b1, CW'(k), DW'(k), 1'b0, 1'b0, 1'b0);
    check_st("full");
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    drain(0, 1'b0);
    cycle(1'b1, 4'd5, DW'(9), 1'b1, 1'b1, 1'b1);
    check_st("done_ignores");

    // Filtering, freeze, backpressure
    do_reset();
    cycle(1'b1, 4'd2, DW'('h1234), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'd0, DW'('h5555), 1'b0, 1'b0, 1'b0);
    check_st("filter");
    cycle(1'b1, 4'd3, DW'('h7777), 1'b1, 1'b0, 1'b0);
    check_st("freeze");
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'd7, DW'($urandom), 1'b0, 1'b0, 1'b1);
    check_st("frozen_ignores");
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drain(5, 1'b1);

    // Reset mid-drain
    do_reset();
    for (int k = 1; k <= 3; k++) cycle(1'b1, CW'(k), DW'(k * 16), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_st("mid_reset");
    cycle(1'b1, 4'd9, DW'('h3abc), 1'b0, 1'b0, 1'b0);
    check_st("after_reset");
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    drain(0, 1'b1);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(0, 24);
      for (int k = 0; k < n; k++) begin
        cycle($urandom_range(0, 3) != 0, CW'($urandom_range(0, 15)), DW'($urandom),
              (k == n - 3) && r[0], 1'b0, 1'($urandom_range(0, 1)));
      end
      check_st($sformatf("rand%0d", r));
      cycle(1'b1, CW'($urandom_range(1, 15)), DW'($urandom), 1'b0, 1'b1, 1'b0);
      drain($urandom_range(0, 4), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios2_oci_trace_capture.md
Name: nios2_oci_trace_capture

Overview:
- Parametrised successor to the OCI test-bench data-trace hook: a synthesizable capture buffer, not a passive sink.
- Records data-capture-trace (DCT) frames from the Nios II OCI into a circular buffer.
- Freezes on test_ending; drains the buffer over a valid/ready read port after test_has_ended.
- Sits beside the OCI debug module and feeds a JTAG/host readout or simulation checker.

Parameters:
DCT_W, 30, width of dct_buffer frame
CNT_W, 4, width of dct_count
DEPTH, 16, buffer entries; power of two, >= 2
WRAP_MODE, 1, 1 = overwrite oldest when full; 0 = drop newest when full
OVF_W, 16, width of saturating overflow counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dct_valid  in  1  dct_buffer/dct_count valid this cycle
dct_buffer  in  DCT_W  trace frame payload
dct_count  in  CNT_W  number of valid sub-entries in frame; 0 = empty frame
test_ending  in  1  request freeze of capture
test_has_ended  in  1  request drain
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  rd_data holds oldest stored entry
rd_data  out  CNT_W+DCT_W  {dct_count, dct_buffer} of oldest entry
level  out  clog2(DEPTH+1)  entries stored
overflow_cnt  out  OVF_W  frames lost (dropped or overwritten), saturating
frozen  out  1  capture stopped
drain_done  out  1  drain completed, buffer empty

Behaviour:
- Reset (clk edge with reset=1): state=CAPTURE, pointers=0, level=0, overflow_cnt=0, rd_valid=0, frozen=0, drain_done=0, rd_data=0. Reset is honoured in every state, mid-drain included; contents are discarded.
- Write qualifier: dct_valid=1 and dct_count!=0, accepted only in CAPTURE. Frames with dct_count=0 are ignored and not counted.
- States:
  - CAPTURE: qualified frame written at wr_ptr; level+1.
    - Full with WRAP_MODE=1: oldest entry overwritten, rd_ptr advances, level stays DEPTH, overflow_cnt+1.
    - Full with WRAP_MODE=0: frame discarded, overflow_cnt+1.
    - test_ending=1 -> FROZEN. A frame presented in the same cycle is still captured.
    - test_has_ended=1, with or without test_ending -> DRAIN; same-cycle frame is still captured.
  - FROZEN: frozen=1; no writes. test_has_ended -> DRAIN.
  - DRAIN: frozen=1; rd_valid=(level!=0) starting the cycle after entry.
    - Pop on rd_valid&&rd_ready: rd_ptr+1, level-1; the next entry appears on rd_data the following cycle.
    - rd_data holds stable while rd_valid=1 and rd_ready=0.
    - level=0 -> DONE.
  - DONE: drain_done=1, frozen=1, rd_valid=0. Terminal until reset. test_* inputs are ignored.
- Pointer wrap: modulo DEPTH (natural wrap of clog2(DEPTH) bits); level disambiguates full from empty.
- overflow_cnt saturates at 2^OVF_W-1.
- rd_valid, frozen and drain_done are registered. rd_data is first-word-fall-through from registered storage; no combinational path from rd_ready to rd_valid.
- Entering DRAIN with level=0: one DRAIN cycle, then DONE.
- rd_ready is a don't-care outside DRAIN.

Decomposition:
- Shared package nios2_oci_trace_pkg holds:
  - state enum (CAPTURE, FROZEN, DRAIN, DONE)
  - entry width function (CNT_W+DCT_W)
  - saturating-increment helper
- One sub-module, nios2_oci_trace_ram: DEPTH x (CNT_W+DCT_W) simple dual-port register array, one write port, async-read port.
- Control FSM, pointers and counters live in the top.

Test Plan:
- Basic capture/drain: reset, write 3 frames (count=1,2,3; data=0x1,0x2,0x3), pulse test_has_ended, rd_ready=1 -> rd_data {1,0x1},{2,0x2},{3,0x3} on consecutive cycles; then drain_done=1, level=0.
- Wrap overwrite: DEPTH=4, WRAP_MODE=1, write frames 1..6 -> level=4, overflow_cnt=2; drain yields 3,4,5,6.
- Drop-when-full: DEPTH=4, WRAP_MODE=0, write frames 1..6 -> overflow_cnt=2; drain yields 1,2,3,4.
- Freeze and filtering:
  - frame with dct_count=0 -> level unchanged.
  - test_ending together with a frame -> that frame stored, frozen=1.
  - subsequent frames -> ignored, level unchanged.
- Backpressure: in DRAIN, hold rd_ready=0 for 5 cycles -> rd_valid=1, rd_data unchanged; release -> entries pop one per cycle.
- Reset mid-drain: after 1 of 3 entries popped, assert reset -> next cycle level=0, rd_valid=0, frozen=0, state CAPTURE; a new frame is captured normally.
